// File: rtl/clk_rate_ctrl.sv
// PHY common-clock sequencer: holds the PLL output gated until lock is stable,
// then serves run-time DataBusWidth changes by gating, reloading and ungating PCLK.
module clk_rate_ctrl #(
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       Ref_Clk,
    input  logic       Rst,
    input  logic       pll_lock,
    input  logic       width_req_valid,
    input  logic [5:0] width_req,
    output logic       width_req_ready,
    output logic [7:0] div_ratio,
    output logic [5:0] cur_width,
    output logic       clk_gate_en,
    output logic       phy_clk_ready,
    output logic       width_done,
    output logic       err_illegal_width,
    output logic       lock_lost,
    output logic       lock_fail
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES)
                           ? ((LOCK_TIMEOUT > GATE_CYCLES) ? LOCK_TIMEOUT : GATE_CYCLES)
                           : ((SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_SETTLE,
        S_RUN,
        S_GATE,
        S_RELOAD,
        S_UNGATE,
        S_LOCK_FAIL
    } state_t;

    function automatic logic [7:0] ratio_of(input logic [5:0] width);
        case (width)
            6'd8:    ratio_of = 8'd10;
            6'd16:   ratio_of = 8'd20;
            6'd32:   ratio_of = 8'd40;
            default: ratio_of = 8'd0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [5:0]             pend_width_q, pend_width_d;
    logic                   reloaded_q, reloaded_d;
    logic [7:0]             ratio_d;
    logic [5:0]             width_d;
    logic                   ready_d, gate_d, clk_ready_d, done_d, err_d, lost_d, fail_d;
    logic                   lock_s;
    logic                   accept;
    logic                   req_legal;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign req_legal = (ratio_of(width_req) != 8'd0);
    // The ready flop already implies RUN; lock_s lets a same-cycle lock loss win.
    assign accept    = width_req_valid && width_req_ready && lock_s;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_width_d = pend_width_q;
        reloaded_d   = reloaded_q;
        ratio_d      = div_ratio;
        width_d      = cur_width;
        ready_d      = 1'b0;
        gate_d       = 1'b0;
        clk_ready_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        lost_d       = 1'b0;
        fail_d       = 1'b0;

        case (state_q)
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_LOCK_FAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SETTLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RUN: begin
                if (!lock_s) begin
                    state_d    = S_WAIT_LOCK;
                    cnt_d      = '0;
                    lost_d     = 1'b1;
                    reloaded_d = 1'b0;
                end else begin
                    gate_d      = 1'b1;
                    clk_ready_d = 1'b1;
                    ready_d     = 1'b1;
                    // First RUN cycle after a reload reports the completed change.
                    done_d      = reloaded_q;
                    reloaded_d  = 1'b0;
                    if (accept) begin
                        if (!req_legal) begin
                            err_d = 1'b1;
                        end else if (width_req == cur_width) begin
                            done_d = 1'b1;
                        end else begin
                            pend_width_d = width_req;
                            state_d      = S_GATE;
                            cnt_d        = '0;
                            ready_d      = 1'b0;
                        end
                    end
                end
            end

            S_GATE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end else if (cnt_q == GATE_LAST) begin
                    state_d = S_RELOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RELOAD: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end else begin
                    // Enable is released on the same edge that loads the new ratio.
                    gate_d     = 1'b1;
                    ratio_d    = ratio_of(pend_width_q);
                    width_d    = pend_width_q;
                    reloaded_d = 1'b1;
                    state_d    = S_UNGATE;
                    cnt_d      = '0;
                end
            end

            S_UNGATE: begin
                if (!lock_s) begin
                    state_d    = S_WAIT_LOCK;
                    cnt_d      = '0;
                    lost_d     = 1'b1;
                    reloaded_d = 1'b0;
                end else begin
                    gate_d = 1'b1;
                    if (cnt_q == GATE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_LOCK_FAIL: begin
                fail_d = 1'b1;
            end

            default: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Ref_Clk or posedge Rst) begin
        if (Rst) begin
            sync_q            <= '0;
            state_q           <= S_WAIT_LOCK;
            cnt_q             <= '0;
            pend_width_q      <= 6'd8;
            reloaded_q        <= 1'b0;
            div_ratio         <= 8'd10;
            cur_width         <= 6'd8;
            width_req_ready   <= 1'b0;
            clk_gate_en       <= 1'b0;
            phy_clk_ready     <= 1'b0;
            width_done        <= 1'b0;
            err_illegal_width <= 1'b0;
            lock_lost         <= 1'b0;
            lock_fail         <= 1'b0;
        end else begin
            sync_q            <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            pend_width_q      <= pend_width_d;
            reloaded_q        <= reloaded_d;
            div_ratio         <= ratio_d;
            cur_width         <= width_d;
            width_req_ready   <= ready_d;
            clk_gate_en       <= gate_d;
            phy_clk_ready     <= clk_ready_d;
            width_done        <= done_d;
            err_illegal_width <= err_d;
            lock_lost         <= lost_d;
            lock_fail         <= fail_d;
        end
    end

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Self-checking bench for clk_rate_ctrl: directed sequences plus random width
// requests, compared every cycle against a deadline-based behavioural model.
module tb_clk_rate_ctrl;

    localparam int LOCK_TIMEOUT  = 1024;
    localparam int SETTLE_CYCLES = 16;
    localparam int GATE_CYCLES   = 4;
    localparam int SYNC_STAGES   = 2;

    // Model phases: clocks down, lock settling, clocks up, width switch, failed.
    localparam int DOWN     = 0;
    localparam int SETTLING = 1;
    localparam int UP       = 2;
    localparam int SWITCH   = 3;
    localparam int FAILED   = 4;

    logic       Ref_Clk         = 1'b0;
    logic       Rst             = 1'b1;
    logic       pll_lock        = 1'b0;
    logic       width_req_valid = 1'b0;
    logic [5:0] width_req       = 6'd8;
    logic       width_req_ready;
    logic [7:0] div_ratio;
    logic [5:0] cur_width;
    logic       clk_gate_en;
    logic       phy_clk_ready;
    logic       width_done;
    logic       err_illegal_width;
    logic       lock_lost;
    logic       lock_fail;

    always #5 Ref_Clk = ~Ref_Clk;

    clk_rate_ctrl #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .GATE_CYCLES  (GATE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .Ref_Clk          (Ref_Clk),
        .Rst              (Rst),
        .pll_lock         (pll_lock),
        .width_req_valid  (width_req_valid),
        .width_req        (width_req),
        .width_req_ready  (width_req_ready),
        .div_ratio        (div_ratio),
        .cur_width        (cur_width),
        .clk_gate_en      (clk_gate_en),
        .phy_clk_ready    (phy_clk_ready),
        .width_done       (width_done),
        .err_illegal_width(err_illegal_width),
        .lock_lost        (lock_lost),
        .lock_fail        (lock_fail)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: phase, the edge the phase began on, and expected registered outputs.
    bit lock_pipe[$];
    int mode    = DOWN;
    int entry   = 0;
    int pend    = 8;
    bit back_up = 1'b0;
    bit e_ready = 1'b0, e_gate = 1'b0, e_phy = 1'b0, e_done = 1'b0;
    bit e_err   = 1'b0, e_lost = 1'b0, e_fail = 1'b0;
    int e_div   = 10;
    int e_cur   = 8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int ratio_for(input int w);
        case (w)
            8:       return 10;
            16:      return 20;
            32:      return 40;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit lk, was_back;
        bit n_ready, n_gate, n_phy, n_done, n_err, n_lost, n_fail;
        int t;
        cyc++;
        if (Rst) begin
            lock_pipe.delete();
            for (int i = 0; i < SYNC_STAGES; i++) lock_pipe.push_back(1'b0);
            mode = DOWN; entry = cyc; back_up = 1'b0;
            e_ready = 0; e_gate = 0; e_phy = 0; e_done = 0; e_err = 0; e_lost = 0; e_fail = 0;
            e_div = 10; e_cur = 8;
            return;
        end
        lk = lock_pipe.pop_front();
        lock_pipe.push_back(pll_lock);
        t = cyc - entry;
        was_back = back_up;
        back_up  = 1'b0;
        n_ready = 0; n_gate = 0; n_phy = 0; n_done = 0; n_err = 0; n_lost = 0; n_fail = 0;
        case (mode)
            DOWN: begin
                if (lk) begin
                    mode = SETTLING; entry = cyc;
                end else if (t == LOCK_TIMEOUT) begin
                    mode = FAILED;
                end
            end
            SETTLING: begin
                if (!lk) begin
                    mode = DOWN; entry = cyc;
                end else if (t == SETTLE_CYCLES) begin
                    mode = UP; entry = cyc;
                end
            end
            UP: begin
                if (!lk) begin
                    n_lost = 1; mode = DOWN; entry = cyc;
                end else begin
                    n_gate = 1; n_phy = 1; n_ready = 1; n_done = was_back;
                    if (width_req_valid && e_ready) begin
                        if (ratio_for(int'(width_req)) == 0) n_err = 1;
                        else if (int'(width_req) == e_cur) n_done = 1;
                        else begin
                            pend = int'(width_req); mode = SWITCH; entry = cyc; n_ready = 0;
                        end
                    end
                end
            end
            SWITCH: begin
                if (!lk) begin
                    n_lost = 1; mode = DOWN; entry = cyc;
                end else begin
                    n_gate = (t > GATE_CYCLES);
                    if (t == GATE_CYCLES + 1) begin
                        e_div = ratio_for(pend); e_cur = pend;
                    end
                    if (t == 2 * GATE_CYCLES + 1) begin
                        mode = UP; entry = cyc; back_up = 1'b1;
                    end
                end
            end
            default: n_fail = 1;
        endcase
        e_ready = n_ready; e_gate = n_gate; e_phy = n_phy; e_done = n_done;
        e_err = n_err; e_lost = n_lost; e_fail = n_fail;
    endtask

    task automatic compare_all();
        check("width_req_ready", width_req_ready, e_ready);
        check("clk_gate_en", clk_gate_en, e_gate);
        check("phy_clk_ready", phy_clk_ready, e_phy);
        check("width_done", width_done, e_done);
        check("err_illegal_width", err_illegal_width, e_err);
        check("lock_lost", lock_lost, e_lost);
        check("lock_fail", lock_fail, e_fail);
        check("div_ratio", div_ratio, e_div);
        check("cur_width", cur_width, e_cur);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Ref_Clk);
            model_edge();
            @(negedge Ref_Clk);
            compare_all();
        end
    endtask

    // Present a request, wait (bounded) for ready, then complete the handshake edge.
    task automatic do_req(input int w);
        int n = 0;
        width_req       = 6'(w);
        width_req_valid = 1'b1;
        while (width_req_ready !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check("req_ready_seen", width_req_ready, 1'b1);
        step(1);
        width_req_valid = 1'b0;
    endtask

    initial begin
        int n, cnt;
        int pick, w;

        // Reset and first lock.
        step(3);
        check("rst_div_ratio", div_ratio, 10);
        check("rst_cur_width", cur_width, 8);
        check("rst_gate", clk_gate_en, 1'b0);
        Rst = 1'b0;
        step(20);
        pll_lock = 1'b1;
        n = 0;
        do begin step(1); n++; end while (phy_clk_ready !== 1'b1 && n < 100);
        check("lock_to_ready_latency", n - 1, SYNC_STAGES + 1 + SETTLE_CYCLES);
        check("lock_gate_en", clk_gate_en, 1'b1);

        // Illegal width, same width, then a real change to 16.
        do_req(12);
        check("illegal_err_pulse", err_illegal_width, 1'b1);
        step(1);
        check("illegal_err_single", err_illegal_width, 1'b0);
        check("illegal_no_gating", clk_gate_en, 1'b1);
        do_req(8);
        check("same_width_done", width_done, 1'b1);
        do_req(16);
        n = 0; cnt = 0;
        do begin
            step(1); n++;
            if (clk_gate_en === 1'b0) cnt++;
        end while (width_done !== 1'b1 && n < 30);
        check("width_done_latency", n, 2 * GATE_CYCLES + 2);
        check("gate_low_cycles", cnt, GATE_CYCLES);
        check("w16_div_ratio", div_ratio, 20);
        check("w16_cur_width", cur_width, 16);

        // Random request traffic against the model.
        for (int i = 0; i < 30; i++) begin
            pick = int'($urandom_range(0, 4));
            case (pick)
                0: w = 8;
                1: w = 16;
                2: w = 32;
                3: w = 12;
                default: w = int'($urandom_range(0, 63));
            endcase
            step(int'($urandom_range(0, 3)));
            do_req(w);
        end

        // Lock loss during the GATE phase of an 8->32 change.
        do_req(8);
        do_req(32);
        pll_lock = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (lock_lost === 1'b1) cnt++;
        end
        check("gate_lock_lost_pulses", cnt, 1);
        check("gate_loss_div_kept", div_ratio, 10);
        check("gate_loss_gate_off", clk_gate_en, 1'b0);

        // Relock with a 3-cycle glitch during SETTLE.
        pll_lock = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (lock_lost === 1'b1) cnt++;
        end
        pll_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (lock_lost === 1'b1) cnt++;
        end
        pll_lock = 1'b1;
        n = 0;
        while (phy_clk_ready !== 1'b1 && n < 80) begin
            step(1); n++;
            if (lock_lost === 1'b1) cnt++;
        end
        check("settle_glitch_no_lost", cnt, 0);
        check("relock_ready", phy_clk_ready, 1'b1);
        check("relock_cur_width", cur_width, 8);

        // Reset pulse during UNGATE after the ratio was reloaded.
        do_req(16);
        step(GATE_CYCLES + 2);
        Rst = 1'b1;
        pll_lock = 1'b0;
        #1;
        check("rst_async_div", div_ratio, 10);
        check("rst_async_width", cur_width, 8);
        check("rst_async_gate", clk_gate_en, 1'b0);
        @(negedge Ref_Clk);
        step(2);
        Rst = 1'b0;

        // No lock: timeout into the terminal failure state.
        n = 0;
        while (lock_fail !== 1'b1 && n < LOCK_TIMEOUT + 50) begin
            step(1); n++;
        end
        check("lock_fail_latency", n, LOCK_TIMEOUT + 1);
        pll_lock = 1'b1;
        step(40);
        check("lock_fail_sticky", lock_fail, 1'b1);
        check("lock_fail_gate_off", clk_gate_en, 1'b0);
        check("lock_fail_not_ready", phy_clk_ready, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
